fpt_telemetry_uart: RTL and testbench



---
 rtl/fpt_telemetry_pkg.sv | 30 +++
 rtl/fpt_telemetry_uart_tx.sv | 94 +++++++++
 rtl/fpt_telemetry_uart.sv | 154 +++++++++++++++
 tb/tb_fpt_telemetry_uart.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fpt_telemetry_pkg.sv
`default_nettype none
// ============================================================================
// Module : fpt_telemetry_pkg
// Shared frame constants, transmit states and snapshot type for telemetry.
// Rev    : 1.0
// ============================================================================
package fpt_telemetry_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic        veto;
    logic [1:0]  attention;
    logic [15:0] corr;
  } snapshot_t;

  function automatic logic [7:0] pack_status(input snapshot_t snap, input logic [4:0] seq);
    return {snap.veto, snap.attention, seq};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpt_telemetry_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_8n1
// 8N1 byte serializer; ready in idle and in the last stop-bit cycle.
// Rev    : 1.0
// ============================================================================
module uart_tx_8n1
  import fpt_telemetry_pkg::*;
#(
  parameter int BAUD_DIV = 1232
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       byte_valid_i,
  input  logic [7:0] data_i,
  output logic       byte_ready_o,
  output logic       tx_o
);

  localparam int               CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end      = (cnt_q == CNT_LAST);
  assign byte_ready_o = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign tx_o         = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: cnt_d = '0;
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A byte accepted in the final stop cycle starts its start bit with no gap.
    if (byte_valid_i && byte_ready_o) begin
      state_d = START;
      cnt_d   = '0;
      bit_d   = 3'd0;
      shift_d = data_i;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpt_telemetry_uart.sv
`default_nettype none
// ============================================================================
// Module : fpt_telemetry_uart
// Snapshots FPT core outputs on tick/veto edge and sends 5-byte UART frames.
// Rev    : 1.0
// ============================================================================
module fpt_telemetry_uart
  import fpt_telemetry_pkg::*;
#(
  parameter int CLK_HZ       = 142000000,
  parameter int BAUD         = 115200,
  parameter int FRAME_PERIOD = 1420000
) (
  input  logic        clk_142mhz,
  input  logic        rst,
  input  logic [15:0] motor_correction,
  input  logic        veto_in,
  input  logic [1:0]  attention_level,
  input  logic        sensor_valid,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_sent,
  output logic [7:0]  drop_count
);

  localparam int                  BAUD_DIV    = CLK_HZ / BAUD;
  localparam int                  PERIOD_W    = $clog2(FRAME_PERIOD);
  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(FRAME_PERIOD - 1);
  localparam logic [2:0]          LAST_IDX    = 3'(FRAME_BYTES);

  logic [PERIOD_W-1:0] period_q, period_d;
  logic                veto_q;
  snapshot_t           slot_q, slot_d, frame_q, frame_d, snap;
  logic                slot_full_q, slot_full_d;
  logic                busy_q, busy_d;
  logic [2:0]          idx_q, idx_d;
  logic [4:0]          seq_q, seq_d, fseq_q, fseq_d;
  logic [7:0]          drop_q, drop_d;

  logic       tick, veto_edge, trig;
  logic       byte_ready, byte_valid, frame_end, send_next;
  logic       start_slot, start_new, start;
  logic [7:0] byte_data, status_byte;

  assign tick      = (period_q == PERIOD_LAST);
  assign veto_edge = veto_in & ~veto_q;
  assign trig      = veto_edge | (tick & sensor_valid);
  assign snap      = {veto_in, attention_level, motor_correction};

  // idx_q counts bytes already handed to the serializer for the current frame.
  assign frame_end  = busy_q & byte_ready & (idx_q == LAST_IDX);
  assign send_next  = busy_q & byte_ready & (idx_q != LAST_IDX);
  assign start_slot = slot_full_q & (frame_end | ~busy_q);
  assign start_new  = ~busy_q & ~slot_full_q & trig;
  assign start      = start_slot | start_new;
  assign byte_valid = start | send_next;

  always_comb begin
    status_byte = pack_status(frame_q, fseq_q);
    byte_data   = SYNC_BYTE;
    if (!start) begin
      case (idx_q)
        3'd1:    byte_data = status_byte;
        3'd2:    byte_data = frame_q.corr[15:8];
        3'd3:    byte_data = frame_q.corr[7:0];
        3'd4:    byte_data = SYNC_BYTE ^ status_byte ^ frame_q.corr[15:8] ^ frame_q.corr[7:0];
        default: byte_data = SYNC_BYTE;
      endcase
    end
  end

  always_comb begin
    period_d    = tick ? '0 : period_q + 1'b1;
    slot_d      = slot_q;
    slot_full_d = slot_full_q;
    frame_d     = frame_q;
    fseq_d      = fseq_q;
    seq_d       = seq_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    drop_d      = drop_q;

    if (start) begin
      frame_d = start_slot ? slot_q : snap;
      fseq_d  = seq_q;
      seq_d   = seq_q + 1'b1;
      idx_d   = 3'd1;
      busy_d  = 1'b1;
    end else if (send_next) begin
      idx_d = idx_q + 1'b1;
    end else if (frame_end) begin
      busy_d = 1'b0;
    end

    if (start_slot) slot_full_d = 1'b0;

    // Occupancy is judged before any same-cycle load out of the slot.
    if (trig && !start_new) begin
      if (!(busy_q && slot_full_q)) begin
        slot_d      = snap;
        slot_full_d = 1'b1;
      end else begin
        if (drop_q != 8'hFF) drop_d = drop_q + 1'b1;
        if (veto_edge) begin
          slot_d      = snap;
          slot_full_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_142mhz) begin
    if (rst) begin
      period_q    <= '0;
      veto_q      <= 1'b0;
      slot_q      <= '0;
      slot_full_q <= 1'b0;
      frame_q     <= '0;
      fseq_q      <= 5'd0;
      seq_q       <= 5'd0;
      idx_q       <= 3'd0;
      busy_q      <= 1'b0;
      drop_q      <= 8'h00;
    end else begin
      period_q    <= period_d;
      veto_q      <= veto_in;
      slot_q      <= slot_d;
      slot_full_q <= slot_full_d;
      frame_q     <= frame_d;
      fseq_q      <= fseq_d;
      seq_q       <= seq_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  uart_tx_8n1 #(
    .BAUD_DIV(BAUD_DIV)
  ) u_ser (
    .clk_i       (clk_142mhz),
    .rst_i       (rst),
    .byte_valid_i(byte_valid),
    .data_i      (byte_data),
    .byte_ready_o(byte_ready),
    .tx_o        (uart_tx)
  );

  assign busy       = busy_q;
  assign frame_sent = frame_end;
  assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_fpt_telemetry_uart.sv
`default_nettype none
// ============================================================================
// Module : tb_fpt_telemetry_uart
// Directed bench: decodes uart_tx into bytes and compares with hand values.
// Rev    : 1.0
// ============================================================================
module tb_fpt_telemetry_uart;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] motor_correction;
  logic        veto_in;
  logic [1:0]  attention_level;
  logic        sensor_valid;
  logic        uart_tx;
  logic        busy;
  logic        frame_sent;
  logic [7:0]  drop_count;

  int n_vec, n_err, t0, cyc, stop_err;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  fpt_telemetry_uart #(
    .CLK_HZ      (1600),
    .BAUD        (100),
    .FRAME_PERIOD(2000)
  ) dut (
    .clk_142mhz      (clk),
    .rst             (rst),
    .motor_correction(motor_correction),
    .veto_in         (veto_in),
    .attention_level (attention_level),
    .sensor_valid    (sensor_valid),
    .uart_tx         (uart_tx),
    .busy            (busy),
    .frame_sent      (frame_sent),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge inside cycle n (cycle 0 = first cycle out of reset).
  task automatic go(input int n);
    while (cyc - t0 < n) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4, input int t_start);
    logic [7:0] exp_b [5];
    exp_b[0] = 8'hA5; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3; exp_b[4] = b4;
    chk($sformatf("%s_len", tag), rx_q.size() >= 5, 1);
    if (rx_q.size() >= 5) begin
      chk($sformatf("%s_tstart", tag), rx_t[0], t_start);
      chk($sformatf("%s_tlast", tag), rx_t[4], t_start + 640);
      for (int i = 0; i < 5; i++) chk($sformatf("%s_b%0d", tag, i), rx_q[i], exp_b[i]);
      for (int i = 0; i < 5; i++) begin
        void'(rx_q.pop_front());
        void'(rx_t.pop_front());
      end
    end
  endtask

  // Line decoder: sample each bit mid-way (16 cycles per bit).
  initial begin : monitor
    logic [7:0] b;
    int ts;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || uart_tx !== 1'b0) continue;
      ts = cyc - t0;
      repeat (8) @(negedge clk);
      if (uart_tx !== 1'b0) continue;
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (16) @(negedge clk);
      if (uart_tx !== 1'b1) stop_err++;
      rx_q.push_back(b);
      rx_t.push_back(ts);
    end
  end

  initial begin : stim
    rst = 1'b1; veto_in = 1'b0; attention_level = 2'd0; motor_correction = 16'h0000;
    sensor_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      veto_in          = ~veto_in;
      attention_level  = attention_level + 2'd1;
      motor_correction = 16'($urandom);
      sensor_valid     = ~sensor_valid;
      @(negedge clk);
      chk("rst_tx", uart_tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_sent", frame_sent, 0);
      chk("rst_drop", drop_count, 0);
    end
    veto_in = 1'b0; sensor_valid = 1'b1; attention_level = 2'd2; motor_correction = 16'h1234;
    rst = 1'b0;
    t0 = cyc;

    // Periodic frame, then a veto edge queued during its B2
    go(1999); chk("t2_idle_tx", uart_tx, 1); chk("t2_idle_busy", busy, 0);
    go(2000); chk("t2_start_tx", uart_tx, 0); chk("t2_start_busy", busy, 1);
    go(2400); veto_in = 1'b1; attention_level = 2'd3; motor_correction = 16'hFFFE;
    go(2798); chk("t2_sent_early", frame_sent, 0);
    go(2799); chk("t2_sent", frame_sent, 1);
    go(2800); chk("t3_b2b_busy", busy, 1); chk("t3_b2b_tx", uart_tx, 0);
    chk("t3_b2b_sent", frame_sent, 0);
    go(3000); veto_in = 1'b0; sensor_valid = 1'b0;
    go(3599); chk("t3_sent", frame_sent, 1);
    go(3600); chk("t3_busy_low", busy, 0);
    check_frame("t2", 8'h40, 8'h12, 8'h34, 8'hC3, 2000);
    check_frame("t3", 8'hE1, 8'hFF, 8'hFE, 8'h45, 2800);

    // Gated tick at 3999, then a veto edge with sensor_valid low
    go(4000); chk("t5_gate_tx", uart_tx, 1); chk("t5_gate_busy", busy, 0);
    chk("t5_gate_drop", drop_count, 0);
    go(4150); chk("t5_no_frame", rx_q.size(), 0);
    go(4200); veto_in = 1'b1; attention_level = 2'd1; motor_correction = 16'hABCD;
    go(4210); veto_in = 1'b0;
    go(5000); chk("t5_sent", frame_sent, 1);
    go(5100); check_frame("t5", 8'hA2, 8'hAB, 8'hCD, 8'h61, 4201);

    // Overflow: veto fills slot, tick drops, second veto drops and overwrites
    go(5500); veto_in = 1'b1; attention_level = 2'd0; motor_correction = 16'h1111;
    go(5510); veto_in = 1'b0;
    go(5600); veto_in = 1'b1; attention_level = 2'd1; motor_correction = 16'h2222;
    go(5610); veto_in = 1'b0;
    go(5700); chk("t4_drop0", drop_count, 0);
    go(5900); sensor_valid = 1'b1;
    go(6000); chk("t4_drop1", drop_count, 1);
    go(6050); sensor_valid = 1'b0;
    go(6100); veto_in = 1'b1; attention_level = 2'd2; motor_correction = 16'h0042;
    go(6110); veto_in = 1'b0; chk("t4_drop2", drop_count, 2);
    go(6301); chk("t4_b2b_tx", uart_tx, 0); chk("t4_b2b_busy", busy, 1);
    go(7200); check_frame("t4a", 8'h83, 8'h11, 8'h11, 8'h26, 5501);
    check_frame("t4b", 8'hC4, 8'h00, 8'h42, 8'h23, 6301);
    chk("t4_busy_low", busy, 0);

    // Reset during B2 aborts the frame and restarts seq at 0
    go(7500); veto_in = 1'b1; attention_level = 2'd0; motor_correction = 16'h5555;
    go(7510); veto_in = 1'b0;
    go(7900); chk("t6_busy_pre", busy, 1); rst = 1'b1;
    go(7901); chk("t6_rst_tx", uart_tx, 1); chk("t6_rst_busy", busy, 0);
    chk("t6_rst_drop", drop_count, 0);
    rst = 1'b0;
    go(8100);
    chk("t6_partial_b1", (rx_q.size() >= 2) ? rx_q[1] : 8'h00, 8'h85);
    rx_q.delete();
    rx_t.delete();
    go(8200); veto_in = 1'b1; attention_level = 2'd3; motor_correction = 16'h0001;
    go(8210); veto_in = 1'b0;
    go(9100); check_frame("t6", 8'hE0, 8'h00, 8'h01, 8'h44, 8201);
    chk("stop_err", stop_err, 0);
    chk("rx_empty", rx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
